// File: rtl/audio_pkg.sv
// Shared audio-path constants and the envelope state encoding.
package audio_pkg;

  localparam logic [11:0] AUDIO_MID = 12'd2048;
  localparam logic [7:0]  ENV_MAX   = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/adsr_envelope_scale.sv
// Sample scaler: recentres the offset-binary sample, multiplies by the envelope
// level and re-biases. Kept in its own module so the multiplier maps to a DSP.
module env_scale
  import audio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [11:0] sample_in,
  input  logic [7:0]  level,
  output logic [11:0] sample_out
);

  logic signed [12:0] w_c;
  logic signed [21:0] w_p;
  logic signed [21:0] w_sh;
  logic        [11:0] r_out;

  assign w_c  = $signed({1'b0, sample_in}) - $signed({1'b0, AUDIO_MID});
  assign w_p  = 22'(w_c) * 22'($signed({1'b0, level}));
  // Level <= 255 keeps |p>>>8| below 2048, so the re-bias never wraps.
  assign w_sh = w_p >>> 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_out <= AUDIO_MID;
    else if (sample_tick) r_out <= w_sh[11:0] + AUDIO_MID;
  end

  assign sample_out = r_out;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope between the tone generator and the PWM DAC.
// All state advances only on sample_tick; gate edges take priority over stepping.
module adsr_envelope
  import audio_pkg::*;
#(
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 1,
  parameter int SUSTAIN_LEVEL = 192,
  parameter int RELEASE_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        note_gate,
  input  logic [11:0] sample_in,
  output logic [11:0] sample_out,
  output logic [7:0]  env_level,
  output logic        busy
);

  localparam logic [8:0] ATK_THR = 9'(255 - ATTACK_STEP);
  localparam logic [8:0] DEC_THR = 9'(SUSTAIN_LEVEL + DECAY_STEP);
  localparam logic [8:0] REL_THR = 9'(RELEASE_STEP);
  localparam logic [7:0] ATK_INC = 8'(ATTACK_STEP);
  localparam logic [7:0] DEC_DEC = 8'(DECAY_STEP);
  localparam logic [7:0] REL_DEC = 8'(RELEASE_STEP);
  localparam logic [7:0] SUS_LVL = 8'(SUSTAIN_LEVEL);

  env_state_e r_state, w_state_nx;
  logic [7:0] r_level, w_level_nx;
  logic       r_gate_q;
  logic       w_rise, w_fall;

  assign w_rise = note_gate & ~r_gate_q;
  assign w_fall = ~note_gate & r_gate_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_level  <= '0;
      r_gate_q <= 1'b0;
    end else if (sample_tick) begin
      r_state  <= w_state_nx;
      r_level  <= w_level_nx;
      r_gate_q <= note_gate;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_level_nx = r_level;
    if (w_rise) begin
      // Re-trigger continues from the current level rather than restarting at 0.
      if (r_state != ST_ATTACK) w_state_nx = ST_ATTACK;
    end else if (w_fall) begin
      if (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) w_state_nx = ST_RELEASE;
    end else begin
      case (r_state)
        ST_IDLE: w_level_nx = '0;
        ST_ATTACK: begin
          if ({1'b0, r_level} >= ATK_THR) begin
            w_level_nx = ENV_MAX;
            w_state_nx = ST_DECAY;
          end else begin
            w_level_nx = r_level + ATK_INC;
          end
        end
        ST_DECAY: begin
          if ({1'b0, r_level} <= DEC_THR) begin
            w_level_nx = SUS_LVL;
            w_state_nx = ST_SUSTAIN;
          end else begin
            w_level_nx = r_level - DEC_DEC;
          end
        end
        ST_SUSTAIN: w_level_nx = r_level;
        ST_RELEASE: begin
          if ({1'b0, r_level} <= REL_THR) begin
            w_level_nx = '0;
            w_state_nx = ST_IDLE;
          end else begin
            w_level_nx = r_level - REL_DEC;
          end
        end
        default: begin
          w_level_nx = '0;
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Scaling uses the pre-update level, giving one tick of sample latency.
  env_scale u_scale (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .sample_in  (sample_in),
    .level      (r_level),
    .sample_out (sample_out)
  );

  assign env_level = r_level;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: scoreboard of per-tick expectations
// from a behavioural envelope model, plus directed checks at the key points.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        note_gate = 1'b0;
  logic [11:0] sample_in = 12'd0;
  logic [11:0] sample_out;
  logic [7:0]  env_level;
  logic        busy;

  adsr_envelope dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .note_gate  (note_gate),
    .sample_in  (sample_in),
    .sample_out (sample_out),
    .env_level  (env_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lvl;
    logic [11:0] smp;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   m_st, m_lvl, m_out;
  bit   m_gq;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_lvl = 0; m_out = 2048; m_gq = 1'b0;
    sb.delete();
  endtask

  // Envelope model with the default parameters (8, 1, 192, 2).
  task automatic m_tick(input bit g, input int s);
    int p;
    bit rise, fall;
    p     = (s - 2048) * m_lvl;
    m_out = ((p >>> 8) + 2048) & 32'hFFF;
    rise  = g & ~m_gq;
    fall  = ~g & m_gq;
    m_gq  = g;
    if (rise) begin
      if (m_st != 1) m_st = 1;
    end else if (fall) begin
      if (m_st >= 1 && m_st <= 3) m_st = 4;
    end else begin
      case (m_st)
        0: m_lvl = 0;
        1: if (m_lvl + 8 >= 255) begin m_lvl = 255; m_st = 2; end else m_lvl = m_lvl + 8;
        2: if (m_lvl - 1 <= 192) begin m_lvl = 192; m_st = 3; end else m_lvl = m_lvl - 1;
        4: if (m_lvl - 2 <= 0)   begin m_lvl = 0;   m_st = 0; end else m_lvl = m_lvl - 2;
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit g, input int s, input int gap);
    exp_t e;
    @(negedge clk);
    note_gate   = g;
    sample_in   = 12'(s);
    sample_tick = 1'b1;
    m_tick(g, s);
    e.lvl = 8'(m_lvl);
    e.smp = 12'(m_out);
    e.bsy = (m_st != 0);
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("lvl",  32'(env_level),  32'(e.lvl));
      chk("out",  32'(sample_out), 32'(e.smp));
      chk("busy", 32'(busy),       32'(e.bsy));
    end
    repeat (gap) begin
      @(negedge clk);
      sample_tick = 1'b0;
      sample_in   = 12'($urandom_range(0, 4095));
      @(posedge clk); #1;
      chk("hold_lvl", 32'(env_level),  32'(m_lvl));
      chk("hold_out", 32'(sample_out), 32'(m_out));
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 4095));
  endfunction

  initial begin
    int n;
    m_reset();
    rst_n = 1'b0; note_gate = 1'b0; sample_in = 12'd4095; sample_tick = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_out",  32'(sample_out), 32'd2048);
      chk("rst_lvl",  32'(env_level),  32'd0);
      chk("rst_busy", 32'(busy),       32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) tick(1'b0, 4095, 0);
    chk("idle_out",  32'(sample_out), 32'd2048);
    chk("idle_busy", 32'(busy),       32'd0);

    // Attack, decay, sustain with ticks every 4 clocks
    tick(1'b1, 2148, 3);
    chk("rise_lvl", 32'(env_level), 32'd0);
    chk("rise_st",  32'(dut.r_state), 32'd1);
    tick(1'b1, 3000, 3);
    chk("atk2", 32'(env_level), 32'd8);
    for (int i = 3; i <= 33; i++) tick(1'b1, rnd(), 3);
    chk("atk_top",  32'(env_level), 32'd255);
    chk("st_decay", 32'(dut.r_state), 32'd2);
    tick(1'b1, 4095, 3);
    chk("full_hi", 32'(sample_out), 32'd4087);
    chk("dec1",    32'(env_level),  32'd254);
    for (int i = 35; i <= 96; i++) tick(1'b1, rnd(), 3);
    chk("sus_lvl", 32'(env_level), 32'd192);
    chk("st_sus",  32'(dut.r_state), 32'd3);
    repeat (5) tick(1'b1, rnd(), 3);
    chk("sus_hold", 32'(env_level), 32'd192);

    // Release
    tick(1'b0, rnd(), 3);
    chk("fall_st",  32'(dut.r_state), 32'd4);
    chk("fall_lvl", 32'(env_level),   32'd192);
    tick(1'b0, rnd(), 3);
    chk("rel1", 32'(env_level), 32'd190);
    for (int k = 2; k <= 32; k++) tick(1'b0, rnd(), 3);
    chk("rel128", 32'(env_level), 32'd128);
    tick(1'b0, 3072, 3);
    chk("half", 32'(sample_out), 32'd2560);
    for (int k = 34; k <= 95; k++) tick(1'b0, rnd(), 3);
    chk("rel95_lvl",  32'(env_level), 32'd2);
    chk("rel95_busy", 32'(busy),      32'd1);
    tick(1'b0, rnd(), 3);
    chk("rel_end",  32'(env_level), 32'd0);
    chk("rel_idle", 32'(busy),      32'd0);

    // Full-scale low sample, then re-trigger from mid release
    tick(1'b1, rnd(), 3);
    n = 0;
    while (m_lvl != 255 && n < 40) begin tick(1'b1, rnd(), 3); n++; end
    chk("reach255", 32'(env_level), 32'd255);
    tick(1'b1, 0, 3);
    chk("full_lo", 32'(sample_out), 32'd8);
    tick(1'b0, rnd(), 3);
    n = 0;
    while (m_lvl != 100 && n < 200) begin tick(1'b0, rnd(), 3); n++; end
    chk("rel_at100", 32'(env_level), 32'd100);
    tick(1'b1, rnd(), 3);
    chk("re_rise_lvl", 32'(env_level),   32'd100);
    chk("re_rise_st",  32'(dut.r_state), 32'd1);
    tick(1'b1, rnd(), 3);
    chk("re_atk", 32'(env_level), 32'd108);

    // Asynchronous reset between ticks in the middle of attack
    tick(1'b1, 4095, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lvl",  32'(env_level),   32'd0);
    chk("arst_out",  32'(sample_out),  32'd2048);
    chk("arst_busy", 32'(busy),        32'd0);
    chk("arst_st",   32'(dut.r_state), 32'd0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1, rnd(), 3);
    chk("post_rise_st",   32'(dut.r_state), 32'd1);
    chk("post_rise_busy", 32'(busy),        32'd1);
    chk("post_rise_lvl",  32'(env_level),   32'd0);
    tick(1'b1, rnd(), 3);
    chk("post_atk", 32'(env_level), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
